uart_tx: RTL
============

Name: uart_tx

Overview:
- Serial UART transmitter; upstream counterpart of the receive stage.
- Drives the serial line that the receiver samples.
- Accepts parallel words over a valid/ready handshake and shifts them out LSB-first as an N-bit frame: start bit, data, optional even parity, 1 or 2 stop bits.
- Bit timing comes from an internal clock-cycle divider; no external baud tick.

Parameters:
CLKS_PER_BIT, 4, clock cycles each serial bit is held; legal range >= 1
DATA_BITS, 8, data bits per frame; legal range 5..8
PARITY_EN, 0, 1 = append even-parity bit after data; 0 = no parity bit
STOP_BITS, 1, number of stop bits; legal values 1 or 2

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
data_in  input  DATA_BITS  word to transmit; sampled only on handshake
tx_valid  input  1  upstream has a word on data_in
tx_ready  output  1  block can accept a word this cycle
tx  output  1  serial line out; idle high
busy  output  1  high while a frame is on the line

Behaviour:
- All outputs registered. Reset (sync, active-high) forces:
  - state=IDLE, tx=1, tx_ready=1, busy=0
  - bit and cycle counters cleared; shift register cleared
- tx_valid is ignored while reset is high.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: tx=1, tx_ready=1, busy=0.
  - Handshake occurs on the edge where tx_valid && tx_ready.
  - That edge latches data_in into the shift register, computes parity (XOR of data bits), enters START, and drives tx_ready=0, busy=1.
- START: tx=0 for CLKS_PER_BIT cycles, then DATA.
- DATA: tx=shift_reg[0] for CLKS_PER_BIT cycles per bit; shift right after each bit. After DATA_BITS bits, go to PARITY if PARITY_EN=1, else STOP.
- PARITY: tx=even-parity bit, so the total count of ones across data+parity is even. Held CLKS_PER_BIT cycles, then STOP.
- STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles, then IDLE.
- Frame length F = 1 + DATA_BITS + PARITY_EN + STOP_BITS bits.
  - tx_ready stays low for exactly F*CLKS_PER_BIT cycles after the accept edge.
  - It returns high in the first IDLE cycle.
- Minimum inter-frame gap is 1 idle clock with tx=1, i.e. the accept cycle. With tx_valid held high, frames repeat with period F*CLKS_PER_BIT+1 cycles.
- Changes to data_in or tx_valid while tx_ready=0 have no effect. The word latched at the handshake is transmitted unaltered.
- Cycle counter width is clog2(CLKS_PER_BIT) (min 1). It wraps from CLKS_PER_BIT-1 to 0 on each bit boundary.
- CLKS_PER_BIT=1 is legal: one bit per clock, no divider stall.
- Reset asserted mid-frame aborts the frame. The next cycle has tx=1 and tx_ready=1; no partial stop bit or glitch low is emitted after reset.
- No underflow or overflow conditions exist: the single-word buffer is the shift register, and backpressure is via tx_ready.

Test Plan:
- Reset release, tx_valid=0 for 20 cycles -> tx=1, tx_ready=1, busy=0 throughout.
- Defaults (CLKS_PER_BIT=4, 8N1); send 0xA5 -> tx sequence 0,1,0,1,0,0,1,0,1,1, each held 4 cycles. tx_ready low exactly 40 cycles; busy high the same 40 cycles.
- PARITY_EN=1, STOP_BITS=2, CLKS_PER_BIT=2; send 0x07 -> start 0, data 1,1,1,0,0,0,0,0, parity 1, stop 1,1. Frame is 12 bits = 24 cycles.
- tx_valid held high with data 0x55 then 0xFF (CLKS_PER_BIT=1) -> two frames separated by exactly one idle high cycle. Second frame carries 0xFF; data_in changes during frame 1 do not corrupt it.
- Reset asserted at cycle 15 of a 0x00 frame (CLKS_PER_BIT=4) -> next cycle tx=1, tx_ready=1, busy=0. A new 0x3C send afterward is transmitted correctly.
- tx_valid pulsed while busy=1 -> pulse ignored, no extra frame, line stays high after the current frame's stop bit.

Source files
------------

// File: rtl/uart_tx.sv
// uart_tx: valid/ready fed UART transmitter.
// Frames LSB-first with optional even parity and 1 or 2 stop bits.
module uart_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = $clog2(DATA_BITS);

    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = (STOP_BITS == 2);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 stop_q, stop_d;
    logic                 tx_q, tx_d;
    logic                 ready_q, ready_d;
    logic                 busy_q, busy_d;
    logic                 bit_end;

    // Last clock of the current serial bit.
    assign bit_end = (cnt_q == CNT_LAST);

    // Next-state logic; tx is computed one cycle early so it can be a flop.
    always_comb begin
        state_d = state_q;
        cnt_d   = bit_end ? '0 : cnt_q + CW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        stop_d  = stop_q;
        tx_d    = tx_q;
        ready_d = ready_q;
        busy_d  = busy_q;

        unique case (state_q)
            IDLE: begin
                cnt_d   = '0;
                bit_d   = '0;
                stop_d  = 1'b0;
                tx_d    = 1'b1;
                ready_d = 1'b1;
                busy_d  = 1'b0;
                if (tx_valid && ready_q) begin
                    shift_d = data_in;
                    par_d   = ^data_in;
                    state_d = START;
                    tx_d    = 1'b0;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                end
            end

            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    tx_d    = shift_q[0];
                end
            end

            DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_LAST) begin
                        bit_d = '0;
                        if (PARITY_EN != 0) begin
                            state_d = PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + BW'(1);
                        tx_d  = shift_q[1];
                    end
                end
            end

            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end

            STOP: begin
                tx_d = 1'b1;
                if (bit_end) begin
                    if (stop_q == STOP_LAST) begin
                        state_d = IDLE;
                        stop_d  = 1'b0;
                        ready_d = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        stop_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                bit_d   = '0;
                stop_d  = 1'b0;
                tx_d    = 1'b1;
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            stop_q  <= 1'b0;
            tx_q    <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            stop_q  <= stop_d;
            tx_q    <= tx_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    assign tx       = tx_q;
    assign tx_ready = ready_q;
    assign busy     = busy_q;

endmodule
